parking_occupancy_ctrl: RTL

Downstream stage of the entry/exit sensor decoder. Consumes its increment/decrement level outputs and keeps the occupied-spot count, saturating at capacity. Drives the free-spot count, the full/empty flags, a three-lamp availability sign (green/yellow/red) and two BCD digits for the entrance display. Reports sticky error flags for overflow and underflow events.

---
 rtl/parking_occupancy_ctrl_if.sv | 58 +++++
 rtl/parking_occupancy_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/parking_occupancy_ctrl_if.sv
// ----------------------------------------------------------------------------
// parking_occupancy_ctrl_if
// Bundles the sensor-decoder inputs and the occupancy/display outputs of the
// parking occupancy controller.
//
// Signals:
//   increment_i / decrement_i     car-entered / car-left levels (into the ctrl)
//   occupancy_o / free_spots_o    occupied and free spot counts (CNT_W bits)
//   full_o / empty_o              count at CAPACITY / at zero
//   lamp_green_o/yellow_o/red_o   one-hot availability sign
//   bcd_tens_o / bcd_ones_o       decimal digits of the free-spot count
//   overflow_err_o/underflow_err_o sticky rejected-event flags
//   total_entries_o/total_exits_o traffic counters (PARK_TRAFFIC_STATS_EN only)
//
// Modports: master = sensor side / observer, slave = controller.
// Optional macro: PARK_TRAFFIC_STATS_EN adds the traffic counter signals.
// ----------------------------------------------------------------------------
interface parking_occupancy_ctrl_if #(
    parameter int CNT_W = 7
);
    logic             increment_i;
    logic             decrement_i;
    logic [CNT_W-1:0] occupancy_o;
    logic [CNT_W-1:0] free_spots_o;
    logic             full_o;
    logic             empty_o;
    logic             lamp_green_o;
    logic             lamp_yellow_o;
    logic             lamp_red_o;
    logic [3:0]       bcd_tens_o;
    logic [3:0]       bcd_ones_o;
    logic             overflow_err_o;
    logic             underflow_err_o;
`ifdef PARK_TRAFFIC_STATS_EN
    logic [15:0]      total_entries_o;
    logic [15:0]      total_exits_o;
`endif

    modport master (
        output increment_i, decrement_i,
        input  occupancy_o, free_spots_o, full_o, empty_o,
        input  lamp_green_o, lamp_yellow_o, lamp_red_o,
        input  bcd_tens_o, bcd_ones_o, overflow_err_o, underflow_err_o
`ifdef PARK_TRAFFIC_STATS_EN
        , input total_entries_o, total_exits_o
`endif
    );

    modport slave (
        input  increment_i, decrement_i,
        output occupancy_o, free_spots_o, full_o, empty_o,
        output lamp_green_o, lamp_yellow_o, lamp_red_o,
        output bcd_tens_o, bcd_ones_o, overflow_err_o, underflow_err_o
`ifdef PARK_TRAFFIC_STATS_EN
        , output total_entries_o, total_exits_o
`endif
    );
endinterface

// File: rtl/parking_occupancy_ctrl.sv
// ----------------------------------------------------------------------------
// parking_occupancy_ctrl
// Keeps the occupied-spot count of a car park from the entry/exit sensor
// decoder levels, saturating at CAPACITY, and drives the free-spot count,
// full/empty flags, a green/yellow/red availability lamp, two BCD digits for
// the entrance display and sticky overflow/underflow error flags.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    parking_occupancy_ctrl_if.slave (see interface for signal list)
//
// Parameters: CAPACITY (1..99), ALMOST_TH (< CAPACITY), CNT_W (2^CNT_W > CAPACITY)
// Optional macro: PARK_TRAFFIC_STATS_EN adds 16-bit wrapping counters of
// accepted entries and exits.
// ----------------------------------------------------------------------------
module parking_occupancy_ctrl #(
    parameter int CAPACITY  = 20,
    parameter int ALMOST_TH = 3,
    parameter int CNT_W     = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    parking_occupancy_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] TH       = CNT_W'(ALMOST_TH);
    localparam logic [CNT_W-1:0] TEN      = CNT_W'(10);
    localparam logic [3:0]       CAP_TENS = 4'(CAPACITY / 10);
    localparam logic [3:0]       CAP_ONES = 4'(CAPACITY % 10);

    // One-hot encoding so each lamp is a state bit straight out of a flop.
    typedef enum logic [2:0] {
        GREEN  = 3'b001,
        YELLOW = 3'b010,
        RED    = 3'b100
    } lamp_state_t;

    lamp_state_t      state_q, state_d;
    logic             inc_q, dec_q;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] free_q, free_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [3:0]       tens_q, ones_q;

    logic inc_ev, dec_ev;
    logic accept_inc, accept_dec;

    // Rising-edge events; simultaneous events cancel out entirely.
    assign inc_ev     = bus.increment_i & ~inc_q;
    assign dec_ev     = bus.decrement_i & ~dec_q;
    assign accept_inc = inc_ev & ~dec_ev & ~full_q;
    assign accept_dec = dec_ev & ~inc_ev & ~empty_q;

    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (accept_inc) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (accept_dec) begin
            occ_d = occ_q - CNT_W'(1);
        end
        if (inc_ev && !dec_ev && full_q) begin
            ovf_d = 1'b1;
        end
        if (dec_ev && !inc_ev && empty_q) begin
            unf_d = 1'b1;
        end
        // Derived flags use the next count so they move with occupancy.
        free_d  = CAP - occ_d;
        full_d  = (occ_d == CAP);
        empty_d = (occ_d == '0);
        state_d = GREEN;
        if (free_d == '0) begin
            state_d = RED;
        end else if (free_d <= TH) begin
            state_d = YELLOW;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GREEN;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            occ_q   <= '0;
            free_q  <= CAP;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            tens_q  <= CAP_TENS;
            ones_q  <= CAP_ONES;
        end else begin
            state_q <= state_d;
            inc_q   <= bus.increment_i;
            dec_q   <= bus.decrement_i;
            occ_q   <= occ_d;
            free_q  <= free_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            // Digits trail free_spots by one cycle; free_q never exceeds 99.
            tens_q  <= 4'(free_q / TEN);
            ones_q  <= 4'(free_q % TEN);
        end
    end

`ifdef PARK_TRAFFIC_STATS_EN
    logic [15:0] entries_q, exits_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            entries_q <= '0;
            exits_q   <= '0;
        end else begin
            if (accept_inc) entries_q <= entries_q + 16'd1;
            if (accept_dec) exits_q   <= exits_q + 16'd1;
        end
    end

    assign bus.total_entries_o = entries_q;
    assign bus.total_exits_o   = exits_q;
`endif

    assign bus.occupancy_o     = occ_q;
    assign bus.free_spots_o    = free_q;
    assign bus.full_o          = full_q;
    assign bus.empty_o         = empty_q;
    assign bus.lamp_green_o    = state_q[0];
    assign bus.lamp_yellow_o   = state_q[1];
    assign bus.lamp_red_o      = state_q[2];
    assign bus.bcd_tens_o      = tens_q;
    assign bus.bcd_ones_o      = ones_q;
    assign bus.overflow_err_o  = ovf_q;
    assign bus.underflow_err_o = unf_q;
endmodule
